plic_nctx: RTL and testbench
============================

// Module: plic_nctx
// PURPOSE
//  Parametrised platform-level interrupt controller: NSRC level-sensitive sources, NCTX hart contexts
//  (ctx0 = M-mode, ctx1 = S-mode by default). AXI4-Lite slave on the peripheral bus, standard PLIC map.
//  Adds per-source gateways with claim/complete in-flight tracking, per-context enable/threshold/claim,
//  and registered per-context interrupt lines to the core's mip.MEIP/SEIP.
// PARAMETERS
//  NSRC    31  sources, IDs 1..NSRC; ID 0 reserved ("no interrupt"); legal 1..31
//  NCTX    2   contexts; legal 1..8
//  PRIO_W  3   priority width; priority 0 = never interrupts
// PORTS
//  clk          in   1        single clock, all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  axi_araddr   in   32       read address (byte address, offset from PLIC base)
//  axi_arvalid  in   1        / axi_arready out 1 ; axi_arprot in 3 ignored
//  axi_rdata    out  32       / axi_rresp out 2 ; axi_rvalid out 1 ; axi_rready in 1
//  axi_awaddr   in   32       / axi_awvalid in 1 ; axi_awready out 1 ; axi_awprot in 3 ignored
//  axi_wdata    in   32       / axi_wstrb in 4 (ignored, full-word) ; axi_wvalid in 1 ; axi_wready out 1
//  axi_bresp    out  2        / axi_bvalid out 1 ; axi_bready in 1
//  src_intr     in   NSRC     level interrupt requests; bit i-1 = source ID i
//  eip          out  NCTX     per-context external interrupt pending, registered
// BEHAVIOUR
//  Map: prio[id] 0x000000+4*id; pending 0x001000 (RO, bit id); enable[c] 0x002000+0x80*c (bit id);
//   threshold[c] 0x200000+0x1000*c; claim/complete[c] 0x200004+0x1000*c. Other addr -> resp 2'b10 (SLVERR),
//   read data 0, no state change. Writes to pending, prio[0], bit0 of enable -> OKAY, ignored.
//  Reset: all prio/enable/threshold/pending/in_flight = 0; eip=0; rvalid=bvalid=0; rresp=bresp=0;
//   rdata=0; arready=awready=wready=1.
//  Read: arready = ~rvalid. Accept on arvalid&&arready; rvalid+rdata next cycle; hold until rready.
//  Write: awready = wready = ~bvalid; accept only when awvalid&&wvalid same cycle; state updates on
//   accept edge; bvalid next cycle, hold until bready. Fields narrower than 32 take low bits, rest read 0.
//  Gateway per source: pending set when src_intr=1 && !pending && !in_flight. Level re-sampled after complete.
//  Best[c]: among id with pending&&enable[c][id]&&prio[id]>threshold[c], highest prio; tie -> lowest id;
//   none -> 0. eip[c] <= (best[c]!=0) each cycle (1-cycle latency from state change).
//  Claim read on ctx c: rdata=best[c] sampled at accept; same edge: pending[id]<=0, in_flight[id]<=1.
//   best=0 -> returns 0, no side effect. Claim beats a same-cycle gateway set for that id.
//  Complete write of id on ctx c: in_flight[id]<=0 only if enable[c][id]=1 and 1<=id<=NSRC; else ignored
//   (still OKAY). Completing a non-in-flight id: no effect.
//  Simultaneous read and write accept same cycle: both processed; write state update and claim side
//   effects apply together; read data reflects pre-edge state.
//  Reset mid-transaction drops outstanding responses (rvalid/bvalid=0); master must reissue.
// STRUCTURE
//  plic_pkg.vh: address offsets/strides, resp codes (OKAY/SLVERR), ID 0 constant.
//  Sub-module plic_arbiter (per context, combinational): inputs pending&enable vector, prio array,
//   threshold -> best id; instantiated NCTX times via generate. Top holds regs, gateways, AXI FSM.
// TESTING
//  1 Reset: all regs read 0, eip=0; read 0x3FFFFC -> SLVERR, rdata 0; write it -> bresp 2'b10.
//  2 prio[10]=3, enable[1]=bit10, thr[1]=0, pulse src 10 -> eip[1]=1 next+1 cycle, eip[0]=0;
//    claim[1] read -> 10, eip[1] drops; src 10 held high: pending stays 0 until complete(10) then re-pends.
//  3 prio[1]=5, prio[10]=5 both pending/enabled ctx0 -> claim returns 1; then 10; tie rule holds.
//  4 thr[0]=5 with prio 5 pending -> eip[0]=0, claim=0; thr[0]=4 -> eip[0]=1.
//  5 complete(10) on ctx with enable bit10=0 -> in_flight kept; source never re-pends.
//  6 rready held low 5 cycles: rvalid/rdata stable, arready=0; AR+AW/W accepted same cycle both respond.

Source files
------------

// File: rtl/plic_nctx_pkg.sv
// plic_nctx_pkg: shared constants, register-kind enum and decoded-address struct for the PLIC.
package plic_nctx_pkg;
  localparam int ID_W = 5;
  localparam logic [ID_W-1:0] ID_NONE = '0;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [31:0] PEND_OFF = 32'h0000_1000;
  localparam logic [31:0] EN_BASE = 32'h0000_2000;
  localparam logic [31:0] CTX_BASE = 32'h0020_0000;
  typedef enum logic [2:0] {K_NONE, K_PRIO, K_PEND, K_EN, K_THR, K_CLAIM} kind_e;
  typedef struct packed {
    kind_e            kind;
    logic [ID_W-1:0]  id;
    logic [2:0]       ctx;
  } dec_t;
endpackage

// File: rtl/plic_nctx_arbiter.sv
// plic_nctx_arbiter: picks the highest-priority request above threshold, lowest id on ties.
module plic_nctx_arbiter
  import plic_nctx_pkg::*;
#(
  parameter int NSRC = 31,
  parameter int PRIO_W = 3
) (
  input  logic [NSRC:0]             req,
  input  logic [NSRC:0][PRIO_W-1:0] prio,
  input  logic [PRIO_W-1:0]         thr,
  output logic [ID_W-1:0]           id
);
  logic [PRIO_W-1:0] best_p;
  // Scanning downward with >= lets the lowest id win a priority tie.
  always_comb begin
    id = ID_NONE;
    best_p = '0;
    for (int i = NSRC; i >= 0; i--)
      if (req[i] && prio[i] > thr && prio[i] >= best_p) begin
        id = ID_W'(i);
        best_p = prio[i];
      end
  end
endmodule

// File: rtl/plic_nctx.sv
// plic_nctx: AXI4-Lite PLIC with per-source gateways, per-context enable/threshold/claim and registered eip.
module plic_nctx
  import plic_nctx_pkg::*;
#(
  parameter int NSRC = 31,
  parameter int NCTX = 2,
  parameter int PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     axi_araddr,
  input  logic            axi_arvalid,
  output logic            axi_arready,
  input  logic [2:0]      axi_arprot,
  output logic [31:0]     axi_rdata,
  output logic [1:0]      axi_rresp,
  output logic            axi_rvalid,
  input  logic            axi_rready,
  input  logic [31:0]     axi_awaddr,
  input  logic            axi_awvalid,
  output logic            axi_awready,
  input  logic [2:0]      axi_awprot,
  input  logic [31:0]     axi_wdata,
  input  logic [3:0]      axi_wstrb,
  input  logic            axi_wvalid,
  output logic            axi_wready,
  output logic [1:0]      axi_bresp,
  output logic            axi_bvalid,
  input  logic            axi_bready,
  input  logic [NSRC-1:0] src_intr,
  output logic [NCTX-1:0] eip
);
  logic [NSRC:0][PRIO_W-1:0] prio;
  logic [NCTX-1:0][NSRC:0] en;
  logic [NCTX-1:0][PRIO_W-1:0] thr;
  logic [NCTX-1:0][ID_W-1:0] best;
  logic [NSRC:0] pend, infl, clm, cmask, rd_en, wr_en;
  logic [PRIO_W-1:0] rd_thr;
  logic [ID_W-1:0] rd_best, cid;
  logic [31:0] rdata_n;
  logic ar_fire, aw_fire, comp_ok, unused;
  dec_t rd, wd;

  function automatic dec_t decode(input logic [31:2] a);
    decode = '{kind: K_NONE, id: a[6:2], ctx: 3'd0};
    if (a[31:12] == 20'h0 && a[11:2] <= 10'(NSRC)) decode.kind = K_PRIO;
    else if (a[31:2] == PEND_OFF[31:2]) decode.kind = K_PEND;
    else if (a[31:10] == EN_BASE[31:10] && a[6:2] == 5'h0 && 32'(a[9:7]) < NCTX) begin
      decode.kind = K_EN;
      decode.ctx = a[9:7];
    end else if (a[31:15] == CTX_BASE[31:15] && a[11:3] == 9'h0 && 32'(a[14:12]) < NCTX) begin
      decode.kind = a[2] ? K_CLAIM : K_THR;
      decode.ctx = a[14:12];
    end
  endfunction

  assign rd = decode(axi_araddr[31:2]);
  assign wd = decode(axi_awaddr[31:2]);
  assign axi_arready = ~axi_rvalid;
  assign axi_awready = ~axi_bvalid;
  assign axi_wready = ~axi_bvalid;
  assign ar_fire = axi_arvalid & axi_arready;
  assign aw_fire = axi_awvalid & axi_wvalid & axi_awready;
  assign cid = axi_wdata[ID_W-1:0];
  assign unused = ^{axi_arprot, axi_awprot, axi_wstrb, axi_araddr[1:0], axi_awaddr[1:0]};

  for (genvar c = 0; c < NCTX; c++) begin : g_ctx
    plic_nctx_arbiter #(.NSRC(NSRC), .PRIO_W(PRIO_W)) u_arb (
      .req  (pend & en[c]),
      .prio (prio),
      .thr  (thr[c]),
      .id   (best[c])
    );
  end

  always_comb begin
    rd_en = '0;
    wr_en = '0;
    rd_thr = '0;
    rd_best = ID_NONE;
    cmask = '0;
    clm = '0;
    for (int c = 0; c < NCTX; c++) begin
      if (rd.ctx == 3'(c)) begin
        rd_en = en[c];
        rd_thr = thr[c];
        rd_best = best[c];
      end
      if (wd.ctx == 3'(c)) wr_en = en[c];
    end
    rdata_n = rd.kind == K_PRIO  ? 32'(prio[rd.id]) :
              rd.kind == K_PEND  ? 32'(pend) :
              rd.kind == K_EN    ? 32'(rd_en) :
              rd.kind == K_THR   ? 32'(rd_thr) :
              rd.kind == K_CLAIM ? 32'(rd_best) : 32'h0;
    comp_ok = aw_fire && wd.kind == K_CLAIM && axi_wdata != 32'h0 &&
              axi_wdata <= 32'(NSRC) && wr_en[cid];
    if (comp_ok) cmask[cid] = 1'b1;
    if (ar_fire && rd.kind == K_CLAIM && rd_best != ID_NONE) clm[rd_best] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= '0;
      en <= '0;
      thr <= '0;
      pend <= '0;
      infl <= '0;
      eip <= '0;
      axi_rvalid <= 1'b0;
      axi_rdata <= '0;
      axi_rresp <= RESP_OKAY;
      axi_bvalid <= 1'b0;
      axi_bresp <= RESP_OKAY;
    end else begin
      // A claim on the same edge overrides the gateway setting that id again.
      pend <= (pend | ({src_intr, 1'b0} & ~infl)) & ~clm;
      infl <= (infl & ~cmask) | clm;
      for (int c = 0; c < NCTX; c++) eip[c] <= best[c] != ID_NONE;
      if (aw_fire && wd.kind == K_PRIO && wd.id != ID_NONE) prio[wd.id] <= axi_wdata[PRIO_W-1:0];
      for (int c = 0; c < NCTX; c++)
        if (aw_fire && wd.ctx == 3'(c)) begin
          if (wd.kind == K_EN) en[c] <= {axi_wdata[NSRC:1], 1'b0};
          if (wd.kind == K_THR) thr[c] <= axi_wdata[PRIO_W-1:0];
        end
      if (ar_fire) begin
        axi_rvalid <= 1'b1;
        axi_rdata <= rdata_n;
        axi_rresp <= rd.kind == K_NONE ? RESP_SLVERR : RESP_OKAY;
      end else if (axi_rready) axi_rvalid <= 1'b0;
      if (aw_fire) begin
        axi_bvalid <= 1'b1;
        axi_bresp <= wd.kind == K_NONE ? RESP_SLVERR : RESP_OKAY;
      end else if (axi_bready) axi_bvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_plic_nctx.sv
// tb_plic_nctx: directed scenario tasks for the PLIC with hand-computed expectations.
module tb_plic_nctx;
  logic clk = 1'b0, rst;
  logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
  logic axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [2:0] axi_arprot, axi_awprot;
  logic [3:0] axi_wstrb;
  logic [1:0] axi_rresp, axi_bresp;
  logic [30:0] src_intr;
  logic [1:0] eip;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  plic_nctx #(.NSRC(31), .NCTX(2), .PRIO_W(3)) dut (
    .clk(clk), .rst(rst),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arprot(axi_arprot),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awprot(axi_awprot),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .src_intr(src_intr), .eip(eip)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    axi_araddr = a; axi_arvalid = 1'b1; axi_rready = 1'b1; n = 0;
    while (axi_arready !== 1'b1 && n < 20) begin cyc(1); n++; end
    cyc(1);
    axi_arvalid = 1'b0; n = 0;
    while (axi_rvalid !== 1'b1 && n < 20) begin cyc(1); n++; end
    tests++;
    if (n == 20) begin fails++; $display("FAIL rd_timeout addr=%h: rvalid=%b want 1", a, axi_rvalid); end
    d = axi_rdata; r = axi_rresp;
    cyc(1);
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] v, output logic [1:0] r);
    int n;
    axi_awaddr = a; axi_wdata = v; axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1; n = 0;
    while (axi_awready !== 1'b1 && n < 20) begin cyc(1); n++; end
    cyc(1);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; n = 0;
    while (axi_bvalid !== 1'b1 && n < 20) begin cyc(1); n++; end
    tests++;
    if (n == 20) begin fails++; $display("FAIL wr_timeout addr=%h: bvalid=%b want 1", a, axi_bvalid); end
    r = axi_bresp;
    cyc(1);
  endtask

  task automatic test_reset();
    logic [31:0] d, addrs [9];
    logic [1:0] r;
    addrs = '{32'h4, 32'h28, 32'h1000, 32'h2000, 32'h2080, 32'h200000, 32'h201000, 32'h200004, 32'h201004};
    tests++;
    if ({axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid, eip} !== 7'b1110000) begin
      fails++;
      $display("FAIL reset_hs: got %b want 1110000", {axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid, eip});
    end
    foreach (addrs[i]) begin
      axi_rd(addrs[i], d, r);
      tests++;
      if ({r, d} !== 34'h0) begin fails++; $display("FAIL reset_reg %h: got resp=%b data=%h want 00/0", addrs[i], r, d); end
    end
    axi_rd(32'h3FFFFC, d, r);
    tests++;
    if (r !== 2'b10 || d !== 32'h0) begin fails++; $display("FAIL bad_rd: got resp=%b data=%h want 10/0", r, d); end
    axi_wr(32'h3FFFFC, 32'h7, r);
    tests++;
    if (r !== 2'b10) begin fails++; $display("FAIL bad_wr: got bresp=%b want 10", r); end
  endtask

  task automatic test_claim_basic();
    logic [31:0] d;
    logic [1:0] r;
    axi_wr(32'h28, 32'd3, r);
    axi_wr(32'h2080, 32'h400, r);
    axi_wr(32'h201000, 32'd0, r);
    src_intr[9] = 1'b1;
    cyc(1);
    tests++;
    if (eip !== 2'b00) begin fails++; $display("FAIL eip_latency: got %b want 00", eip); end
    src_intr[9] = 1'b0;
    cyc(1);
    tests++;
    if (eip !== 2'b10) begin fails++; $display("FAIL eip_ctx1: got %b want 10", eip); end
    axi_rd(32'h201004, d, r);
    tests++;
    if (d !== 32'd10 || r !== 2'b00) begin fails++; $display("FAIL claim10: got %0d/%b want 10/00", d, r); end
    tests++;
    if (eip !== 2'b00) begin fails++; $display("FAIL eip_drop: got %b want 00", eip); end
    src_intr[9] = 1'b1;
    cyc(3);
    axi_rd(32'h1000, d, r);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL inflight_pend: got %h want 0", d); end
    axi_wr(32'h201004, 32'd10, r);
    axi_rd(32'h1000, d, r);
    tests++;
    if (d !== 32'h400) begin fails++; $display("FAIL repend: got %h want 400", d); end
    src_intr[9] = 1'b0;
    axi_rd(32'h201004, d, r);
    tests++;
    if (d !== 32'd10) begin fails++; $display("FAIL reclaim10: got %0d want 10", d); end
    axi_wr(32'h201004, 32'd10, r);
  endtask

  task automatic test_tie();
    logic [31:0] d;
    logic [1:0] r;
    axi_wr(32'h4, 32'd5, r);
    axi_wr(32'h28, 32'd5, r);
    axi_wr(32'h2000, 32'h402, r);
    src_intr[0] = 1'b1; src_intr[9] = 1'b1;
    cyc(1);
    src_intr[0] = 1'b0; src_intr[9] = 1'b0;
    axi_rd(32'h200004, d, r);
    tests++;
    if (d !== 32'd1) begin fails++; $display("FAIL tie_first: got %0d want 1", d); end
    axi_rd(32'h200004, d, r);
    tests++;
    if (d !== 32'd10) begin fails++; $display("FAIL tie_second: got %0d want 10", d); end
    axi_rd(32'h200004, d, r);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL tie_empty: got %0d want 0", d); end
    axi_wr(32'h200004, 32'd1, r);
    axi_wr(32'h200004, 32'd10, r);
  endtask

  task automatic test_threshold();
    logic [31:0] d;
    logic [1:0] r;
    axi_wr(32'h200000, 32'd5, r);
    src_intr[9] = 1'b1;
    cyc(1);
    src_intr[9] = 1'b0;
    cyc(2);
    tests++;
    if (eip[0] !== 1'b0) begin fails++; $display("FAIL thr_block_eip: got %b want 0", eip[0]); end
    axi_rd(32'h200004, d, r);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL thr_block_claim: got %0d want 0", d); end
    axi_wr(32'h200000, 32'd4, r);
    tests++;
    if (eip[0] !== 1'b1) begin fails++; $display("FAIL thr_pass_eip: got %b want 1", eip[0]); end
    axi_rd(32'h200004, d, r);
    tests++;
    if (d !== 32'd10) begin fails++; $display("FAIL thr_pass_claim: got %0d want 10", d); end
    axi_wr(32'h200004, 32'd10, r);
  endtask

  task automatic test_complete_disabled();
    logic [31:0] d;
    logic [1:0] r;
    axi_wr(32'h2080, 32'h0, r);
    src_intr[9] = 1'b1;
    cyc(2);
    axi_rd(32'h200004, d, r);
    tests++;
    if (d !== 32'd10) begin fails++; $display("FAIL cd_claim: got %0d want 10", d); end
    axi_wr(32'h201004, 32'd10, r);
    tests++;
    if (r !== 2'b00) begin fails++; $display("FAIL cd_bresp: got %b want 00", r); end
    cyc(3);
    axi_rd(32'h1000, d, r);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL cd_kept: got %h want 0", d); end
    axi_wr(32'h200004, 32'd10, r);
    axi_rd(32'h1000, d, r);
    tests++;
    if (d !== 32'h400) begin fails++; $display("FAIL cd_release: got %h want 400", d); end
    src_intr[9] = 1'b0;
    axi_rd(32'h200004, d, r);
    axi_wr(32'h200004, 32'd10, r);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0] r;
    axi_araddr = 32'h28; axi_arvalid = 1'b1; axi_rready = 1'b0;
    cyc(1);
    axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({axi_rvalid, axi_arready, axi_rdata} !== {2'b10, 32'd5}) begin
        fails++;
        $display("FAIL stall_%0d: got rvalid=%b arready=%b data=%0d want 1/0/5", i, axi_rvalid, axi_arready, axi_rdata);
      end
      cyc(1);
    end
    axi_rready = 1'b1;
    cyc(1);
    tests++;
    if (axi_rvalid !== 1'b0) begin fails++; $display("FAIL stall_release: got rvalid=%b want 0", axi_rvalid); end
    axi_araddr = 32'h200000; axi_arvalid = 1'b1;
    axi_awaddr = 32'h200000; axi_wdata = 32'd6; axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
    cyc(1);
    axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    tests++;
    if ({axi_rvalid, axi_rdata, axi_bvalid, axi_bresp} !== {1'b1, 32'd4, 1'b1, 2'b00}) begin
      fails++;
      $display("FAIL dual: got rvalid=%b rdata=%0d bvalid=%b bresp=%b want 1/4/1/00", axi_rvalid, axi_rdata, axi_bvalid, axi_bresp);
    end
    cyc(1);
    tests++;
    if ({axi_rvalid, axi_bvalid} !== 2'b00) begin fails++; $display("FAIL dual_done: got %b want 00", {axi_rvalid, axi_bvalid}); end
    axi_rd(32'h200000, d, r);
    tests++;
    if (d !== 32'd6) begin fails++; $display("FAIL dual_thr: got %0d want 6", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    axi_araddr = '0; axi_arvalid = 1'b0; axi_arprot = '0; axi_rready = 1'b1;
    axi_awaddr = '0; axi_awvalid = 1'b0; axi_awprot = '0; axi_wdata = '0; axi_wstrb = 4'hF;
    axi_wvalid = 1'b0; axi_bready = 1'b1; src_intr = '0;
    cyc(3);
    rst = 1'b0;
    test_reset();
    test_claim_basic();
    test_tie();
    test_threshold();
    test_complete_disabled();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
